// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory, holds the returned word for the decoder, and takes PC
// redirects from the jump/branch path.
module instr_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,        // asynchronous, active-low
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_data,
    input  logic              mem_valid,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc_plus1
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0] pc_plus1_q, pc_plus1_d;
    // Set while the single outstanding response belongs to a pre-redirect PC.
    logic              squash_q, squash_d;

    logic [ADDR_W-1:0] pc_inc;

    // PC increment wraps naturally at the address width.
    assign pc_inc      = pc_q + PC_ONE;

    assign mem_addr    = pc_q;
    assign mem_rd      = (state_q == S_REQ);
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus1    = pc_plus1_q;

    // Next-state logic: redirect outranks stall and sequencing outside IDLE.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instr_pc_d    = instr_pc_q;
        pc_plus1_d    = pc_plus1_q;
        squash_d      = squash_q;

        case (state_q)
            S_IDLE: begin
                // One dead cycle after reset; redirects are not accepted yet.
                state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_WAIT;
                if (redirect) begin
                    // The read just issued targets the old PC; discard its data.
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                    squash_d      = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                    if (mem_valid) begin
                        // Response lands this cycle: drop it and refetch.
                        state_d = S_REQ;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (mem_valid) begin
                    if (squash_q) begin
                        // Stale response; pc already holds the redirect target.
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        instr_d       = mem_data;
                        instr_pc_d    = pc_q;
                        pc_plus1_d    = pc_inc;
                        pc_d          = pc_inc;
                        instr_valid_d = 1'b1;
                        state_d       = S_VALID;
                    end
                end
            end
            S_VALID: begin
                if (redirect) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= '0;
            pc_plus1_q    <= '0;
            squash_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instr_pc_q    <= instr_pc_d;
            pc_plus1_q    <= pc_plus1_d;
            squash_q      <= squash_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run checked
// against a fetch-stream scoreboard (expected address sequence and memory image).
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic        mem_valid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus1;

    // Second instance starting at the top of the address space.
    logic [15:0] w_mem_addr;
    logic        w_mem_rd;
    logic [15:0] w_instr;
    logic        w_instr_valid;
    logic [15:0] w_instr_pc;
    logic [15:0] w_pc_plus1;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .mem_valid(mem_valid),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_valid(instr_valid),
        .instr_pc(instr_pc), .pc_plus1(pc_plus1)
    );

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .reset(reset),
        .mem_addr(w_mem_addr), .mem_rd(w_mem_rd),
        .mem_data(mem_data), .mem_valid(mem_valid),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(w_instr), .instr_valid(w_instr_valid),
        .instr_pc(w_instr_pc), .pc_plus1(w_pc_plus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image used by the randomized run.
    function automatic logic [15:0] data_of(input logic [15:0] a);
        logic [31:0] p;
        p = {16'h0000, a} * 32'd40503;
        return p[15:0] ^ 16'hC3A5;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_valid = 1'b0; mem_data = 16'h0000;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL reset_instr: got %h want 0000", instr); end
        checks++; if (instr_pc !== 16'h0000 || pc_plus1 !== 16'h0000) begin failures++; $display("FAIL reset_pcs: got %h/%h want 0000/0000", instr_pc, pc_plus1); end
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        checks++; if (w_mem_addr !== 16'hFFFF) begin failures++; $display("FAIL reset_wrap_addr: got %h want ffff", w_mem_addr); end
        $display("test_reset done");
    endtask

    task automatic test_basic_and_wrap();
        mem_data = 16'h5105;
        reset = 1'b1;
        step();  // IDLE -> REQ
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("FAIL basic_first_req: got rd=%b addr=%h want rd=1 addr=0000", mem_rd, mem_addr); end
        checks++; if (w_mem_rd !== 1'b1 || w_mem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_first_req: got rd=%b addr=%h want rd=1 addr=ffff", w_mem_rd, w_mem_addr); end
        step();  // REQ -> WAIT
        checks++; if (mem_rd !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL basic_wait: got rd=%b valid=%b want 0/0", mem_rd, instr_valid); end
        mem_valid = 1'b1;
        step();  // capture
        mem_valid = 1'b0;
        checks++; if (instr !== 16'h5105 || instr_valid !== 1'b1) begin failures++; $display("FAIL basic_instr: got %h valid=%b want 5105 valid=1", instr, instr_valid); end
        checks++; if (instr_pc !== 16'h0000 || pc_plus1 !== 16'h0001 || mem_addr !== 16'h0001) begin failures++; $display("FAIL basic_pcs: got pc=%h p1=%h addr=%h want 0000/0001/0001", instr_pc, pc_plus1, mem_addr); end
        checks++; if (w_instr_pc !== 16'hFFFF || w_pc_plus1 !== 16'h0000 || w_instr !== 16'h5105 || w_instr_valid !== 1'b1) begin failures++; $display("FAIL wrap_pcs: got pc=%h p1=%h instr=%h v=%b want ffff/0000/5105/1", w_instr_pc, w_pc_plus1, w_instr, w_instr_valid); end
        step();  // VALID -> REQ
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0001 || instr_valid !== 1'b0) begin failures++; $display("FAIL basic_second_req: got rd=%b addr=%h v=%b want 1/0001/0", mem_rd, mem_addr, instr_valid); end
        checks++; if (w_mem_rd !== 1'b1 || w_mem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_second_req: got rd=%b addr=%h want 1/0000", w_mem_rd, w_mem_addr); end
        step();
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        checks++; if (instr_pc !== 16'h0001 || instr_valid !== 1'b1) begin failures++; $display("FAIL basic_second_instr: got pc=%h v=%b want 0001/1", instr_pc, instr_valid); end
        checks++; if (w_instr_pc !== 16'h0000 || w_pc_plus1 !== 16'h0001) begin failures++; $display("FAIL wrap_second_instr: got pc=%h p1=%h want 0000/0001", w_instr_pc, w_pc_plus1); end
        $display("test_basic_and_wrap done");
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_valid = i[0];          // stray responses outside WAIT are ignored
            mem_data  = 16'($urandom);
            step();
            checks++; if (instr_valid !== 1'b1 || instr !== 16'h5105 || instr_pc !== 16'h0001 || mem_rd !== 1'b0) begin failures++; $display("FAIL stall_hold: got v=%b instr=%h pc=%h rd=%b want 1/5105/0001/0", instr_valid, instr, instr_pc, mem_rd); end
        end
        stall = 1'b0; mem_valid = 1'b0;
        step();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0002) begin failures++; $display("FAIL stall_release: got rd=%b addr=%h want 1/0002", mem_rd, mem_addr); end
        $display("test_stall done");
    endtask

    task automatic test_redirect_wait();
        step();  // REQ -> WAIT
        redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 16'h0040) begin failures++; $display("FAIL redir_wait: got v=%b rd=%b addr=%h want 0/0/0040", instr_valid, mem_rd, mem_addr); end
        step();
        mem_valid = 1'b1; mem_data = 16'hDEAD;
        step();
        mem_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin failures++; $display("FAIL redir_squash: got v=%b rd=%b addr=%h want 0/1/0040", instr_valid, mem_rd, mem_addr); end
        step();
        mem_valid = 1'b1; mem_data = 16'h1234;
        step();
        mem_valid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 16'h0040 || pc_plus1 !== 16'h0041) begin failures++; $display("FAIL redir_target: got v=%b instr=%h pc=%h p1=%h want 1/1234/0040/0041", instr_valid, instr, instr_pc, pc_plus1); end
        $display("test_redirect_wait done");
    endtask

    task automatic test_redirect_coincident();
        step();  // VALID -> REQ
        step();  // REQ -> WAIT
        mem_valid = 1'b1; mem_data = 16'hBEEF;
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        mem_valid = 1'b0; redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0100) begin failures++; $display("FAIL coincident_drop: got v=%b rd=%b addr=%h want 0/1/0100", instr_valid, mem_rd, mem_addr); end
        step();
        mem_valid = 1'b1; mem_data = 16'h0F0F;
        step();
        mem_valid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h0F0F || instr_pc !== 16'h0100) begin failures++; $display("FAIL coincident_nosquash: got v=%b instr=%h pc=%h want 1/0f0f/0100", instr_valid, instr, instr_pc); end
        $display("test_redirect_coincident done");
    endtask

    task automatic test_reset_mid();
        step();  // VALID -> REQ
        step();  // REQ -> WAIT
        reset = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 16'h0000 || pc_plus1 !== 16'h0000) begin failures++; $display("FAIL midreset_outputs: got v=%b instr=%h pc=%h p1=%h want 0/0000/0000/0000", instr_valid, instr, instr_pc, pc_plus1); end
        checks++; if (mem_rd !== 1'b0 || mem_addr !== 16'h0000) begin failures++; $display("FAIL midreset_mem: got rd=%b addr=%h want 0/0000", mem_rd, mem_addr); end
        @(negedge clk);
        reset = 1'b1; mem_valid = 1'b1; mem_data = 16'hBAD1;
        step();
        mem_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("FAIL midreset_late: got v=%b rd=%b addr=%h want 0/1/0000", instr_valid, mem_rd, mem_addr); end
        step();
        mem_valid = 1'b1; mem_data = 16'h7777;
        step();
        mem_valid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h7777 || instr_pc !== 16'h0000) begin failures++; $display("FAIL midreset_restart: got v=%b instr=%h pc=%h want 1/7777/0000", instr_valid, instr, instr_pc); end
        $display("test_reset_mid done");
    endtask

    // Randomized run: the scoreboard tracks the address the next fetched
    // instruction must come from (last redirect target, else previous + 1).
    task automatic test_random();
        logic [15:0] exp_fetch;
        logic [15:0] cur_pc;
        logic [15:0] resp_addr;
        bit          pending;
        int          wait_cnt;
        bit          p_valid, p_stall, p_redir;
        int          n_fetch;
        exp_fetch = 16'h0000; cur_pc = 16'h0000; resp_addr = 16'h0000;
        pending = 1'b0; wait_cnt = 0; n_fetch = 0;
        p_valid = 1'b0; p_stall = 1'b0; p_redir = 1'b0;
        stall = 1'b0; redirect = 1'b0; mem_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            step();
            // Decoder-side view
            if (p_redir || (p_valid && !p_stall)) begin
                checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_drop: cycle %0d got valid=%b want 0", i, instr_valid); end
            end else if (p_valid && p_stall) begin
                checks++; if (instr_valid !== 1'b1 || instr !== data_of(cur_pc) || instr_pc !== cur_pc) begin failures++; $display("FAIL rnd_hold: cycle %0d got v=%b instr=%h pc=%h want 1/%h/%h", i, instr_valid, instr, instr_pc, data_of(cur_pc), cur_pc); end
            end else if (instr_valid === 1'b1) begin
                checks++; if (instr_pc !== exp_fetch || instr !== data_of(exp_fetch) || pc_plus1 !== 16'(exp_fetch + 16'd1)) begin failures++; $display("FAIL rnd_fetch: cycle %0d got pc=%h instr=%h p1=%h want %h/%h/%h", i, instr_pc, instr, pc_plus1, exp_fetch, data_of(exp_fetch), 16'(exp_fetch + 16'd1)); end
                $display("fetch cycle=%0d pc=%h instr=%h", i, instr_pc, instr);
                cur_pc    = exp_fetch;
                exp_fetch = exp_fetch + 16'd1;
                n_fetch++;
            end
            // Memory side: single outstanding read, latency 1..3 cycles
            if (mem_rd === 1'b1) begin
                checks++; if (pending || mem_addr !== exp_fetch) begin failures++; $display("FAIL rnd_req: cycle %0d got addr=%h outstanding=%0d want addr=%h outstanding=0", i, mem_addr, pending, exp_fetch); end
                pending   = 1'b1;
                resp_addr = mem_addr;
                wait_cnt  = $urandom_range(0, 2);
                mem_valid = 1'b0;
                mem_data  = 16'($urandom);
            end else if (pending && wait_cnt == 0) begin
                mem_valid = 1'b1;
                mem_data  = data_of(resp_addr);
                pending   = 1'b0;
            end else begin
                if (pending) wait_cnt--;
                mem_valid = 1'b0;
                mem_data  = 16'($urandom);
            end
            // Downstream stimulus
            stall    = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            if (redirect) begin
                if ($urandom_range(0, 1) == 1) redirect_pc = 16'($urandom);
                else redirect_pc = 16'hFFFE + 16'($urandom_range(0, 3));
                exp_fetch = redirect_pc;
            end
            p_valid = (instr_valid === 1'b1);
            p_stall = stall;
            p_redir = redirect;
        end
        stall = 1'b0; redirect = 1'b0; mem_valid = 1'b0;
        checks++; if (n_fetch < 50) begin failures++; $display("FAIL rnd_progress: got %0d fetches want at least 50", n_fetch); end
        $display("test_random done fetches=%0d", n_fetch);
    endtask

    initial begin
        test_reset();
        test_basic_and_wrap();
        test_stall();
        test_redirect_wait();
        test_redirect_coincident();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
